// File: rtl/hazard_tracker_if.sv
// Decoder-side hazard bus: D-stage instruction info in, stall/forward selects out.
interface hazard_tracker_if #(parameter int CNT_W = 16);
    logic [4:0]       Rs_D_In;
    logic [4:0]       Rt_D_In;
    logic [1:0]       Tuse_Rs_In;
    logic [1:0]       Tuse_Rt_In;
    logic [1:0]       Tnew_In;
    logic [4:0]       A3_D_In;
    logic             RegWrite_In;
    logic             Stall_Out;
    logic [1:0]       Fwd_Rs_D_Out;
    logic [1:0]       Fwd_Rt_D_Out;
    logic [1:0]       Fwd_Rs_E_Out;
    logic [1:0]       Fwd_Rt_E_Out;
    logic             Fwd_Rt_M_Out;
    logic [CNT_W-1:0] Stall_Cnt_Out;

    modport master (
        output Rs_D_In, Rt_D_In, Tuse_Rs_In, Tuse_Rt_In, Tnew_In, A3_D_In, RegWrite_In,
        input  Stall_Out, Fwd_Rs_D_Out, Fwd_Rt_D_Out, Fwd_Rs_E_Out, Fwd_Rt_E_Out,
               Fwd_Rt_M_Out, Stall_Cnt_Out
    );

    modport slave (
        input  Rs_D_In, Rt_D_In, Tuse_Rs_In, Tuse_Rt_In, Tnew_In, A3_D_In, RegWrite_In,
        output Stall_Out, Fwd_Rs_D_Out, Fwd_Rt_D_Out, Fwd_Rs_E_Out, Fwd_Rt_E_Out,
               Fwd_Rt_M_Out, Stall_Cnt_Out
    );
endinterface

// File: rtl/hazard_tracker.sv
// Tuse/Tnew hazard unit: tracks E/M/W destination shadows, drives stall,
// forwarding selects and a saturating stall-cycle counter.
module hazard_tracker #(
    parameter int CNT_W = 16
) (
    input logic             Clk,
    input logic             Reset_N,
    hazard_tracker_if.slave bus
);

    logic [4:0]       a3_e_q, a3_e_d, rs_e_q, rs_e_d, rt_e_q, rt_e_d;
    logic [1:0]       tnew_e_q, tnew_e_d;
    logic [4:0]       a3_m_q, a3_m_d, rt_m_q, rt_m_d;
    logic [1:0]       tnew_m_q, tnew_m_d;
    logic [4:0]       a3_w_q, a3_w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       a3_eff;
    logic             stall;

    // Stall when a producer in E or M will not have its result before the consumer needs it.
    function automatic logic need_stall(input logic [4:0] r, input logic [1:0] tuse,
                                        input logic [4:0] a3e, input logic [1:0] tne,
                                        input logic [4:0] a3m, input logic [1:0] tnm);
        return (r == a3e && a3e != 5'd0 && tuse < tne) ||
               (r == a3m && a3m != 5'd0 && tuse < tnm);
    endfunction

    // Nearest producer wins; a not-yet-ready producer means read RF now and fix up in E.
    function automatic logic [1:0] fwd_d(input logic [4:0] r,
                                         input logic [4:0] a3e, input logic [1:0] tne,
                                         input logic [4:0] a3m, input logic [1:0] tnm,
                                         input logic [4:0] a3w);
        logic [1:0] sel;
        sel = 2'd0;
        if (r != 5'd0) begin
            if (r == a3e)      sel = (tne == 2'd0) ? 2'd1 : 2'd0;
            else if (r == a3m) sel = (tnm == 2'd0) ? 2'd2 : 2'd0;
            else if (r == a3w) sel = 2'd3;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] r,
                                         input logic [4:0] a3m, input logic [1:0] tnm,
                                         input logic [4:0] a3w);
        logic [1:0] sel;
        sel = 2'd0;
        if (r != 5'd0) begin
            if (r == a3m && tnm == 2'd0) sel = 2'd1;
            else if (r == a3w)           sel = 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        a3_eff = bus.RegWrite_In ? bus.A3_D_In : 5'd0;
        stall  = need_stall(bus.Rs_D_In, bus.Tuse_Rs_In, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q) ||
                 need_stall(bus.Rt_D_In, bus.Tuse_Rt_In, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);

        a3_e_d   = stall ? 5'd0 : a3_eff;
        tnew_e_d = stall ? 2'd0 : bus.Tnew_In;
        rs_e_d   = stall ? 5'd0 : bus.Rs_D_In;
        rt_e_d   = stall ? 5'd0 : bus.Rt_D_In;

        a3_m_d   = a3_e_q;
        tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
        rt_m_d   = rt_e_q;
        a3_w_d   = a3_m_q;

        cnt_d = cnt_q;
        if (stall && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            a3_e_q   <= '0;
            tnew_e_q <= '0;
            rs_e_q   <= '0;
            rt_e_q   <= '0;
            a3_m_q   <= '0;
            tnew_m_q <= '0;
            rt_m_q   <= '0;
            a3_w_q   <= '0;
            cnt_q    <= '0;
        end else begin
            a3_e_q   <= a3_e_d;
            tnew_e_q <= tnew_e_d;
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
            a3_m_q   <= a3_m_d;
            tnew_m_q <= tnew_m_d;
            rt_m_q   <= rt_m_d;
            a3_w_q   <= a3_w_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.Stall_Out     = stall;
    assign bus.Fwd_Rs_D_Out  = fwd_d(bus.Rs_D_In, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
    assign bus.Fwd_Rt_D_Out  = fwd_d(bus.Rt_D_In, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
    assign bus.Fwd_Rs_E_Out  = fwd_e(rs_e_q, a3_m_q, tnew_m_q, a3_w_q);
    assign bus.Fwd_Rt_E_Out  = fwd_e(rt_e_q, a3_m_q, tnew_m_q, a3_w_q);
    assign bus.Fwd_Rt_M_Out  = (rt_m_q == a3_w_q) && (a3_w_q != 5'd0);
    assign bus.Stall_Cnt_Out = cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: ALU, load-use, load-branch, store, $0,
// asynchronous reset and counter saturation (second instance, CNT_W = 2).
module tb_hazard_tracker;

    logic Clk = 1'b0;
    logic Reset_N = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 Clk = ~Clk;

    hazard_tracker_if #(.CNT_W(16)) hif ();
    hazard_tracker_if #(.CNT_W(2))  hsat ();

    assign hsat.Rs_D_In     = hif.Rs_D_In;
    assign hsat.Rt_D_In     = hif.Rt_D_In;
    assign hsat.Tuse_Rs_In  = hif.Tuse_Rs_In;
    assign hsat.Tuse_Rt_In  = hif.Tuse_Rt_In;
    assign hsat.Tnew_In     = hif.Tnew_In;
    assign hsat.A3_D_In     = hif.A3_D_In;
    assign hsat.RegWrite_In = hif.RegWrite_In;

    hazard_tracker #(.CNT_W(16)) dut     (.Clk(Clk), .Reset_N(Reset_N), .bus(hif));
    hazard_tracker #(.CNT_W(2))  dut_sat (.Clk(Clk), .Reset_N(Reset_N), .bus(hsat));

    // A consumer must never reach E while its producer in M is still unfinished.
    always @(negedge Clk) begin
        if (Reset_N) begin
            assert (!(dut.rs_e_q == dut.a3_m_q && dut.a3_m_q != 5'd0 && dut.tnew_m_q != 2'd0))
            else begin
                n_err++;
                $error("FAIL illegal_e_fwd obs=rs_e %0d a3_m %0d tnew_m %0d exp=no match",
                       dut.rs_e_q, dut.a3_m_q, dut.tnew_m_q);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu_rs,
                       input logic [1:0] tu_rt, input logic [1:0] tnew, input logic [4:0] a3,
                       input logic rw);
        hif.Rs_D_In     = rs;
        hif.Rt_D_In     = rt;
        hif.Tuse_Rs_In  = tu_rs;
        hif.Tuse_Rt_In  = tu_rt;
        hif.Tnew_In     = tnew;
        hif.A3_D_In     = a3;
        hif.RegWrite_In = rw;
    endtask

    task automatic nop();
        drv(5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        nop();
        #1 Reset_N = 1'b0;
        #2 Reset_N = 1'b1;
    endtask

    // lw $8 then addu $9,$8,$8: one stall, then both E operands from W
    task automatic seq_load_use(input int base);
        drv(5'd29, 5'd8, 2'd1, 2'd3, 2'd2, 5'd8, 1'b1);
        step();
        drv(5'd8, 5'd8, 2'd1, 2'd1, 2'd1, 5'd9, 1'b1);
        #1;
        chk("lu_stall_c1", hif.Stall_Out, 1);
        chk("lu_fwd_rs_d_c1", hif.Fwd_Rs_D_Out, 0);
        step();
        chk("lu_stall_c2", hif.Stall_Out, 0);
        chk("lu_cnt", hif.Stall_Cnt_Out, base + 1);
        step();
        nop();
        #1;
        chk("lu_fwd_rs_e", hif.Fwd_Rs_E_Out, 2);
        chk("lu_fwd_rt_e", hif.Fwd_Rt_E_Out, 2);
    endtask

    // lw $8 then beq $8,$0: two stalls, then beq reads $8 from W in D
    task automatic seq_load_branch(input int base);
        drv(5'd29, 5'd8, 2'd1, 2'd3, 2'd2, 5'd8, 1'b1);
        step();
        drv(5'd8, 5'd0, 2'd0, 2'd0, 2'd0, 5'd8, 1'b0);
        #1;
        chk("lb_stall_c1", hif.Stall_Out, 1);
        step();
        chk("lb_stall_c2", hif.Stall_Out, 1);
        chk("lb_fwd_rs_d_c2", hif.Fwd_Rs_D_Out, 0);
        step();
        chk("lb_stall_c3", hif.Stall_Out, 0);
        chk("lb_fwd_rs_d", hif.Fwd_Rs_D_Out, 3);
        chk("lb_cnt", hif.Stall_Cnt_Out, base + 2);
    endtask

    initial begin
        nop();
        #2;
        chk("rst_stall", hif.Stall_Out, 0);
        chk("rst_fwd_rs_e", hif.Fwd_Rs_E_Out, 0);
        chk("rst_cnt", hif.Stall_Cnt_Out, 0);
        #6 Reset_N = 1'b1;

        // addu $3,$1,$2 ; subu $4,$3,$5 ; and $10,$3,$3
        drv(5'd1, 5'd2, 2'd1, 2'd1, 2'd1, 5'd3, 1'b1);
        step();
        drv(5'd3, 5'd5, 2'd1, 2'd1, 2'd1, 5'd4, 1'b1);
        #1;
        chk("alu_stall", hif.Stall_Out, 0);
        chk("alu_fwd_rs_d_e", hif.Fwd_Rs_D_Out, 0);
        step();
        drv(5'd3, 5'd3, 2'd1, 2'd1, 2'd1, 5'd10, 1'b1);
        #1;
        chk("alu_fwd_rs_e_m", hif.Fwd_Rs_E_Out, 1);
        chk("alu_fwd_rs_d_m", hif.Fwd_Rs_D_Out, 2);
        chk("alu_fwd_rt_d_m", hif.Fwd_Rt_D_Out, 2);
        step();
        nop();
        #1;
        chk("alu_fwd_rs_e_w", hif.Fwd_Rs_E_Out, 2);
        chk("alu_fwd_rt_e_w", hif.Fwd_Rt_E_Out, 2);
        chk("alu_cnt", hif.Stall_Cnt_Out, 0);

        do_reset();
        seq_load_use(0);

        do_reset();
        seq_load_branch(0);

        // asynchronous reset with beq still forwarding from W and count at 2
        drv(5'd8, 5'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
        #1 Reset_N = 1'b0;
        #1;
        chk("midrst_fwd_rs_d", hif.Fwd_Rs_D_Out, 0);
        chk("midrst_stall", hif.Stall_Out, 0);
        chk("midrst_cnt", hif.Stall_Cnt_Out, 0);
        nop();
        #1 Reset_N = 1'b1;
        step();
        chk("postrst_stall", hif.Stall_Out, 0);
        chk("postrst_fwd_rt_m", hif.Fwd_Rt_M_Out, 0);

        // lw $6 ; sw $6,0($7)
        do_reset();
        drv(5'd29, 5'd6, 2'd1, 2'd3, 2'd2, 5'd6, 1'b1);
        step();
        drv(5'd7, 5'd6, 2'd1, 2'd2, 2'd0, 5'd0, 1'b0);
        #1;
        chk("st_stall", hif.Stall_Out, 0);
        step();
        nop();
        #1;
        chk("st_fwd_rt_e", hif.Fwd_Rt_E_Out, 0);
        step();
        chk("st_fwd_rt_m", hif.Fwd_Rt_M_Out, 1);

        // ori $0,$1,5 ; beq $0,$0
        do_reset();
        drv(5'd1, 5'd0, 2'd1, 2'd3, 2'd1, 5'd0, 1'b1);
        step();
        drv(5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
        #1;
        chk("zero_stall", hif.Stall_Out, 0);
        chk("zero_fwd_rs_d", hif.Fwd_Rs_D_Out, 0);
        chk("zero_fwd_rt_d", hif.Fwd_Rt_D_Out, 0);

        // five stall cycles: narrow counter saturates at 3
        do_reset();
        seq_load_use(0);
        seq_load_branch(1);
        seq_load_branch(3);
        chk("sat_wide_cnt", hif.Stall_Cnt_Out, 5);
        chk("sat_narrow_cnt", {30'd0, hsat.Stall_Cnt_Out}, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Pipeline hazard unit for the five-stage MIPS core. It consumes the per-instruction Tuse/Tnew, register-address and RegWrite information produced by the decoder in D. It keeps its own E/M/W shadow copies of each instruction's destination register and remaining Tnew, and advances them every clock. From these it drives the stall request and the forwarding mux selects for D, E and M, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- CNT_W, 16, width of stall-cycle counter

Ports:
- Clk  in  1  rising-edge clock
- Reset_N  in  1  asynchronous active-low reset
- Rs_D_In  in  5  rs field of instruction in D
- Rt_D_In  in  5  rt field of instruction in D
- Tuse_Rs_In  in  2  decoder Tuse for rs (0 = used in D)
- Tuse_Rt_In  in  2  decoder Tuse for rt
- Tnew_In  in  2  decoder Tnew, counted from entry into E
- A3_D_In  in  5  destination register of D instruction (rd/rt/31)
- RegWrite_In  in  1  D instruction writes the register file
- Stall_Out  out  1  freeze PC and IF/ID; bubble into ID/EX
- Fwd_Rs_D_Out, Fwd_Rt_D_Out  out  2 each  D-operand select: 0 RF, 1 E, 2 M, 3 W
- Fwd_Rs_E_Out, Fwd_Rt_E_Out  out  2 each  E-operand select: 0 pipeline, 1 M, 2 W
- Fwd_Rt_M_Out  out  1  M store-data select: 0 pipeline, 1 W
- Stall_Cnt_Out  out  CNT_W  total stall cycles since reset, saturating

## Operation
- Effective destination: A3 = RegWrite_In ? A3_D_In : 0. Address 0 never matches any consumer.
- Shadow state:
  - E stage: A3_E, Tnew_E, Rs_E, Rt_E.
  - M stage: A3_M, Tnew_M, Rt_M.
  - W stage: A3_W.
- Stall (combinational from D inputs and shadows) is set if any of:
  - Rs_D_In == A3_E, A3_E != 0, Tuse_Rs_In < Tnew_E
  - Rs_D_In == A3_M, A3_M != 0, Tuse_Rs_In < Tnew_M
  - the same two conditions for Rt_D_In / Tuse_Rt_In
- Rt is checked even for I-type instructions. This is conservative; the decoder's Tuse makes it harmless.
- Shadow update each posedge:
  - E from D:
    - Stall = 1: E gets a bubble (all fields 0).
    - Stall = 0: A3_E = A3, Tnew_E = Tnew_In, Rs_E = Rs_D_In, Rt_E = Rt_D_In.
  - M from E: A3_M = A3_E, Tnew_M = max(Tnew_E − 1, 0), Rt_M = Rt_E.
  - W from M: A3_W = A3_M. Tnew_W is implicitly 0.
- D forward, per operand:
  - Consider E, then M, then W, first match by address with A3 != 0.
  - If the first matching stage has Tnew 0, select that stage.
  - If it has Tnew > 0, select 0. The value is taken later at the E forward point, and stall guarantees correctness.
  - No match selects 0.
- E forward, per operand:
  - Match on M with Tnew_M == 0 gives 1.
  - Otherwise a match on W gives 2.
  - Otherwise 0.
  - A match on M with Tnew_M > 0 at the E point is illegal; the bench asserts it never happens.
- M forward: Rt_M == A3_W with A3_W != 0 gives 1.
- Stall counter:
  - Increments on every posedge where Stall_Out = 1.
  - Holds at 2^CNT_W − 1 once reached.

## Timing
- Stall_Out and all Fwd outputs are combinational, valid in the same cycle as the D inputs.
- Shadow registers and the counter update only on the rising edge of Clk.
- Reset_N low asynchronously clears all shadows and Stall_Cnt_Out to 0. Stall_Out and all Fwd outputs therefore read 0 while reset is held.
- Reset deasserting mid-stall resumes with an empty pipeline: no stall and no forwarding.
- A lw→consumer pair with Tuse 1 stalls exactly 1 cycle.
- A lw→beq pair with Tuse 0 stalls 2 cycles.
- An R-type→beq pair with Tuse 0 stalls 1 cycle.
- Back-to-back stalls: each stalled cycle inserts one bubble. D inputs are held externally and re-evaluated every cycle.

## Test plan
- Reset: assert Reset_N = 0 mid-run with non-zero shadows → all outputs 0 immediately. After release with NOP inputs, Stall_Out stays 0.
- R-type→R-type ALU hazard:
  - Stimulus: addu $3,$1,$2 (Tnew 1), then subu $4,$3,$5 (Tuse 1).
  - Required: no stall. Next cycle Fwd_Rs_E_Out = 1; the cycle after that, for a third consumer, Fwd = 2.
- Load-use:
  - Stimulus: lw $8 (Tnew 2), then addu $9,$8,$8.
  - Required: Stall_Out = 1 for 1 cycle, bubble in E, then Fwd_Rs_E_Out = Fwd_Rt_E_Out = 2. Stall_Cnt_Out = 1.
- Load-branch:
  - Stimulus: lw $8, then beq $8,$0.
  - Required: Stall_Out high for 2 consecutive cycles, then Fwd_Rs_D_Out = 3. Stall_Cnt_Out = 2.
- Store data:
  - Stimulus: lw $6, then sw $6,0($7) (Tuse_Rt 2).
  - Required: no stall; Fwd_Rt_M_Out = 1 when sw is in M.
- $0 and counter saturation:
  - Stimulus: ori $0,… followed by beq $0,$0 → no stall and Fwd_Rs_D_Out = 0.
  - Stimulus: with CNT_W = 2, force 5 stall cycles → Stall_Cnt_Out = 3.
